// File: rtl/cpu_pkg.sv
// Shared fetch definitions: opcode width, halt opcode, FSM encoding
// and the IF/ID bundle layout.
package cpu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] HALT_OP = 4'hF;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset load, aligned/wrapped redirect, wrapped +2.
// Ports: clk, rst_n, load+target (redirect), advance, pc (byte address).
module pc_reg #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] target,
  input  logic        advance,
  output logic [15:0] pc
);

  localparam int unsigned SPAN = 2 * MEM_WORDS;
  localparam logic [15:0] LAST = 16'(SPAN - 2);

  logic [15:0] aligned;
  logic [15:0] wrapped;
  logic [15:0] inc;

  assign aligned = target & 16'hFFFE;
  assign wrapped = 16'({16'h0000, aligned} % SPAN);
  // last word wraps back to address 0
  assign inc     = (pc >= LAST) ? 16'h0000 : pc + 16'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= wrapped;
    end else if (advance) begin
      pc <= inc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: RUN/HALT FSM, IF/ID register and saturating fetch counter.
// Ports: clk, rst_n, imem_addr/imem_instr, stall, redirect, redirect_pc,
// resume, if_id_valid/instr/pc, halted, fetch_count.
module instruction_fetch #(
  parameter logic [15:0]                RESET_PC  = 16'h0000,
  parameter int                         MEM_WORDS = 64,
  parameter logic [cpu_pkg::OP_W-1:0]   HALT_OP   = cpu_pkg::HALT_OP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        resume,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  import cpu_pkg::*;

  logic [0:0] state;
  if_id_t     if_id;
  logic [15:0] pc;
  logic       go;
  logic       run;
  logic       is_halt;
  logic       advance;

  assign run     = (state == ST_RUN);
  assign go      = !redirect && !stall;
  assign is_halt = (imem_instr[OP_W-1:0] == HALT_OP);
  assign advance = go && (run ? !is_halt : resume);

  pc_reg #(
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect),
    .target  (redirect_pc),
    .advance (advance),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      if_id       <= '0;
      fetch_count <= 16'h0000;
    end else if (redirect) begin
      state       <= ST_RUN;
      if_id.valid <= 1'b0;
    end else if (!stall) begin
      if (run) begin
        if_id <= '{valid: 1'b1, instr: imem_instr, pc: pc};
        if (fetch_count != 16'hFFFF) begin
          fetch_count <= fetch_count + 16'd1;
        end
        if (is_halt) begin
          state <= ST_HALT;
        end
      end else begin
        if_id.valid <= 1'b0;
        if (resume) begin
          state <= ST_RUN;
        end
      end
    end
  end

  assign imem_addr   = pc;
  assign if_id_valid = if_id.valid;
  assign if_id_instr = if_id.instr;
  assign if_id_pc    = if_id.pc;
  assign halted      = (state == ST_HALT);

endmodule
